tt_um_jleugeri_ttt_token_router: RTL and testbench

TT_UM_JLEUGERI_TTT_TOKEN_ROUTER -- requirements
Module: tt_um_jleugeri_ttt_token_router

---
 rtl/tt_um_jleugeri_ttt_token_router_if.sv | 42 ++++
 rtl/tt_um_jleugeri_ttt_token_router.sv | 166 ++++++++++++++++
 tb/tb_tt_um_jleugeri_ttt_token_router.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/tt_um_jleugeri_ttt_token_router_if.sv
// Bundle for the token router: event handshake, fetch port and connection-table programming.
interface tt_um_jleugeri_ttt_token_router_if #(
  parameter int NEW_TOKEN_BITS  = 4,
  parameter int NUM_PROCESSORS  = 10,
  parameter int NUM_CONNECTIONS = 16
);
  localparam int IDW = $clog2(NUM_PROCESSORS);
  localparam int CAW = $clog2(NUM_CONNECTIONS);

  logic                             ev_valid;
  logic                             ev_ready;
  logic [IDW-1:0]                   ev_source;
  logic [1:0]                       ev_startstop;

  logic                             fetch_en;
  logic [IDW-1:0]                   fetch_id;
  logic signed [NEW_TOKEN_BITS-1:0] new_good_tokens;
  logic signed [NEW_TOKEN_BITS-1:0] new_bad_tokens;

  logic                             prog_en;
  logic [CAW-1:0]                   prog_addr;
  logic                             prog_entry_valid;
  logic [IDW-1:0]                   prog_source;
  logic [IDW-1:0]                   prog_target;
  logic                             prog_is_bad;
  logic signed [NEW_TOKEN_BITS-1:0] prog_weight;
  logic                             prog_dropped;

  modport master (
    output ev_valid, ev_source, ev_startstop,
    output fetch_en, fetch_id,
    output prog_en, prog_addr, prog_entry_valid, prog_source, prog_target, prog_is_bad, prog_weight,
    input  ev_ready, new_good_tokens, new_bad_tokens, prog_dropped
  );

  modport slave (
    input  ev_valid, ev_source, ev_startstop,
    input  fetch_en, fetch_id,
    input  prog_en, prog_addr, prog_entry_valid, prog_source, prog_target, prog_is_bad, prog_weight,
    output ev_ready, new_good_tokens, new_bad_tokens, prog_dropped
  );
endinterface

// File: rtl/tt_um_jleugeri_ttt_token_router.sv
// Token router: scans a connection table on start/stop events and accumulates saturating token deltas per target.
// Optional macro TTT_ROUTER_RETRACT_EN: stop events scan with negated weights.
//
// state | meaning
// IDLE  | accepting events, fetches and table writes
// SCAN  | walking the connection table, one entry per cycle
module tt_um_jleugeri_ttt_token_router #(
  parameter int NEW_TOKEN_BITS  = 4,
  parameter int NUM_PROCESSORS  = 10,
  parameter int NUM_CONNECTIONS = 16
) (
  input logic clock_fast,
  input logic reset,
  tt_um_jleugeri_ttt_token_router_if.slave bus
);
  localparam int IDW = $clog2(NUM_PROCESSORS);
  localparam int CAW = $clog2(NUM_CONNECTIONS);
  localparam int N   = NEW_TOKEN_BITS;

  typedef logic signed [N-1:0] tok_t;
  typedef logic signed [N:0]   wide_t;
  typedef enum logic {IDLE, SCAN} state_t;

  localparam int TOK_MAX = (1 << (N - 1)) - 1;
  localparam int TOK_MIN = -(1 << (N - 1));

  function automatic tok_t sat(input wide_t v);
    if (int'(v) > TOK_MAX) return tok_t'(TOK_MAX);
    if (int'(v) < TOK_MIN) return tok_t'(TOK_MIN);
    return v[N-1:0];
  endfunction

  function automatic tok_t sat_add(input tok_t a, input tok_t d);
    wide_t s;
    s = wide_t'({a[N-1], a}) + wide_t'({d[N-1], d});
    return sat(s);
  endfunction

  state_t         state, state_nxt;
  logic [CAW-1:0] scan_idx;
  logic [IDW-1:0] src_latched;
  logic           sign_neg;

  logic           ent_valid [NUM_CONNECTIONS];
  logic [IDW-1:0] ent_src   [NUM_CONNECTIONS];
  logic [IDW-1:0] ent_tgt   [NUM_CONNECTIONS];
  logic           ent_bad   [NUM_CONNECTIONS];
  tok_t           ent_w     [NUM_CONNECTIONS];

  tok_t acc_good     [NUM_PROCESSORS];
  tok_t acc_bad      [NUM_PROCESSORS];
  tok_t acc_good_nxt [NUM_PROCESSORS];
  tok_t acc_bad_nxt  [NUM_PROCESSORS];

  logic  ready, ev_xfer, start_scan, start_neg, last_entry;
  logic  hit, fetch_ok, prog_ok, prog_drop;
  wide_t w_ext;
  tok_t  delta;

  always_ff @(posedge clock_fast) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    ready      = 1'b0;
    start_scan = 1'b0;
    start_neg  = 1'b0;
    last_entry = (scan_idx == CAW'(NUM_CONNECTIONS - 1));
    ev_xfer    = bus.ev_valid && (state == IDLE);
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (ev_xfer) begin
          if (bus.ev_startstop == 2'b10) begin
            start_scan = 1'b1;
          end
`ifdef TTT_ROUTER_RETRACT_EN
          else if (bus.ev_startstop == 2'b01) begin
            start_scan = 1'b1;
            start_neg  = 1'b1;
          end
`endif
        end
        if (start_scan) state_nxt = SCAN;
      end
      SCAN: begin
        if (last_entry) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.ev_ready = ready;

  // Negation is saturated first, so a retracted most-negative weight adds the positive maximum.
  always_comb begin
    hit   = (state == SCAN) && ent_valid[scan_idx] && (ent_src[scan_idx] == src_latched) &&
            (int'(ent_tgt[scan_idx]) < NUM_PROCESSORS);
    w_ext = wide_t'({ent_w[scan_idx][N-1], ent_w[scan_idx]});
    delta = sat(sign_neg ? -w_ext : w_ext);
  end

  assign fetch_ok  = bus.fetch_en && (int'(bus.fetch_id) < NUM_PROCESSORS);
  assign prog_ok   = bus.prog_en && (state == IDLE) && !bus.ev_valid;
  assign prog_drop = bus.prog_en && !prog_ok;

  // Fetch clear happens before the scan add, so a coincident add lands on zero.
  always_comb begin
    for (int t = 0; t < NUM_PROCESSORS; t++) begin
      acc_good_nxt[t] = acc_good[t];
      acc_bad_nxt[t]  = acc_bad[t];
      if (fetch_ok && (bus.fetch_id == IDW'(t))) begin
        acc_good_nxt[t] = '0;
        acc_bad_nxt[t]  = '0;
      end
      if (hit && (ent_tgt[scan_idx] == IDW'(t))) begin
        if (ent_bad[scan_idx]) acc_bad_nxt[t]  = sat_add(acc_bad_nxt[t], delta);
        else                   acc_good_nxt[t] = sat_add(acc_good_nxt[t], delta);
      end
    end
  end

  always_ff @(posedge clock_fast) begin
    if (reset) begin
      scan_idx            <= '0;
      src_latched         <= '0;
      sign_neg            <= 1'b0;
      bus.new_good_tokens <= '0;
      bus.new_bad_tokens  <= '0;
      bus.prog_dropped    <= 1'b0;
      for (int t = 0; t < NUM_PROCESSORS; t++) begin
        acc_good[t] <= '0;
        acc_bad[t]  <= '0;
      end
      for (int e = 0; e < NUM_CONNECTIONS; e++) ent_valid[e] <= 1'b0;
    end else begin
      if (start_scan) begin
        scan_idx    <= '0;
        src_latched <= bus.ev_source;
        sign_neg    <= start_neg;
      end else if (state == SCAN) begin
        scan_idx <= last_entry ? '0 : scan_idx + 1'b1;
      end
      for (int t = 0; t < NUM_PROCESSORS; t++) begin
        acc_good[t] <= acc_good_nxt[t];
        acc_bad[t]  <= acc_bad_nxt[t];
      end
      bus.new_good_tokens <= fetch_ok ? acc_good[bus.fetch_id] : '0;
      bus.new_bad_tokens  <= fetch_ok ? acc_bad[bus.fetch_id]  : '0;
      if (prog_ok) ent_valid[bus.prog_addr] <= bus.prog_entry_valid;
      if (prog_drop) bus.prog_dropped <= 1'b1;
    end
  end

  // Entry payload needs no reset; valid alone gates its use.
  always_ff @(posedge clock_fast) begin
    if (prog_ok) begin
      ent_src[bus.prog_addr] <= bus.prog_source;
      ent_tgt[bus.prog_addr] <= bus.prog_target;
      ent_bad[bus.prog_addr] <= bus.prog_is_bad;
      ent_w[bus.prog_addr]   <= bus.prog_weight;
    end
  end
endmodule

// File: tb/tb_tt_um_jleugeri_ttt_token_router.sv
// Directed bench for the token router: per-vector single-entry scans plus multi-cycle corner sequences.
module tb_tt_um_jleugeri_ttt_token_router;
  localparam int N  = 4;
  localparam int NP = 10;
  localparam int NC = 16;

`ifdef TTT_ROUTER_RETRACT_EN
  localparam int RET_G    = 7;
  localparam int RET_BUSY = 16;
`else
  localparam int RET_G    = 0;
  localparam int RET_BUSY = 0;
`endif

  logic clock_fast = 1'b0;
  logic reset      = 1'b1;
  always #5 clock_fast = ~clock_fast;

  tt_um_jleugeri_ttt_token_router_if #(.NEW_TOKEN_BITS(N), .NUM_PROCESSORS(NP), .NUM_CONNECTIONS(NC)) bus ();

  tt_um_jleugeri_ttt_token_router #(.NEW_TOKEN_BITS(N), .NUM_PROCESSORS(NP), .NUM_CONNECTIONS(NC)) dut (
    .clock_fast (clock_fast),
    .reset      (reset),
    .bus        (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0]        addr;
    logic              valid;
    logic [3:0]        src;
    logic [3:0]        tgt;
    logic              bad;
    logic signed [3:0] w;
    logic [3:0]        ev_src;
    logic [1:0]        ss;
    logic [3:0]        fid;
    int                exp_good;
    int                exp_bad;
    int                exp_busy;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_fast);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic prog(input logic [3:0] addr, input logic v, input logic [3:0] src, input logic [3:0] tgt,
                      input logic bad, input logic signed [3:0] w);
    bus.prog_en          = 1'b1;
    bus.prog_addr        = addr;
    bus.prog_entry_valid = v;
    bus.prog_source      = src;
    bus.prog_target      = tgt;
    bus.prog_is_bad      = bad;
    bus.prog_weight      = w;
    tick();
    bus.prog_en = 1'b0;
  endtask

  task automatic wait_idle(output int busy);
    busy = 0;
    while (!bus.ev_ready && busy < 40) begin
      busy++;
      tick();
    end
  endtask

  task automatic send_event(input logic [3:0] src, input logic [1:0] ss, output int busy);
    bus.ev_valid     = 1'b1;
    bus.ev_source    = src;
    bus.ev_startstop = ss;
    tick();
    bus.ev_valid = 1'b0;
    wait_idle(busy);
  endtask

  task automatic fetch(input logic [3:0] id, output int g, output int b);
    bus.fetch_en = 1'b1;
    bus.fetch_id = id;
    tick();
    g = int'(bus.new_good_tokens);
    b = int'(bus.new_bad_tokens);
    bus.fetch_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int g, b, busy;
    bus.ev_valid = 0; bus.ev_source = 0; bus.ev_startstop = 0;
    bus.fetch_en = 0; bus.fetch_id = 0;
    bus.prog_en = 0; bus.prog_addr = 0; bus.prog_entry_valid = 0; bus.prog_source = 0;
    bus.prog_target = 0; bus.prog_is_bad = 0; bus.prog_weight = 0;

    //            addr valid src tgt bad  w      evsrc ss     fid  good   bad  busy
    vecs[0] = '{4'd0,  1, 4'd3, 4'd5,  0,  4'sd2,  4'd3, 2'b10, 4'd5,  2,     0,  16};
    vecs[1] = '{4'd0,  1, 4'd3, 4'd5,  0,  4'sd2,  4'd3, 2'b10, 4'd4,  0,     0,  16};
    vecs[2] = '{4'd0,  1, 4'd3, 4'd5,  0,  4'sd2,  4'd2, 2'b10, 4'd5,  0,     0,  16};
    vecs[3] = '{4'd0,  1, 4'd1, 4'd2,  1, -4'sd3,  4'd1, 2'b10, 4'd2,  0,    -3,  16};
    vecs[4] = '{4'd0,  0, 4'd3, 4'd5,  0,  4'sd2,  4'd3, 2'b10, 4'd5,  0,     0,  16};
    vecs[5] = '{4'd0,  1, 4'd3, 4'd10, 0,  4'sd2,  4'd3, 2'b10, 4'd10, 0,     0,  16};
    vecs[6] = '{4'd0,  1, 4'd1, 4'd2,  0, -4'sd8,  4'd1, 2'b01, 4'd2,  RET_G, 0,  RET_BUSY};
    vecs[7] = '{4'd0,  1, 4'd1, 4'd2,  0, -4'sd8,  4'd1, 2'b10, 4'd2, -8,     0,  16};
    vecs[8] = '{4'd0,  1, 4'd3, 4'd5,  0,  4'sd2,  4'd3, 2'b11, 4'd5,  0,     0,  0};
    vecs[9] = '{4'd15, 1, 4'd3, 4'd5,  0,  4'sd5,  4'd3, 2'b10, 4'd5,  5,     0,  16};

    reset = 1'b1;
    tick();
    tick();
    chk("reset.ev_ready", int'(bus.ev_ready), 1);
    chk("reset.good", int'(bus.new_good_tokens), 0);
    chk("reset.bad", int'(bus.new_bad_tokens), 0);
    chk("reset.prog_dropped", int'(bus.prog_dropped), 0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      do_reset();
      prog(vecs[i].addr, vecs[i].valid, vecs[i].src, vecs[i].tgt, vecs[i].bad, vecs[i].w);
      send_event(vecs[i].ev_src, vecs[i].ss, busy);
      chk($sformatf("vec%0d.busy", i), busy, vecs[i].exp_busy);
      fetch(vecs[i].fid, g, b);
      chk($sformatf("vec%0d.good", i), g, vecs[i].exp_good);
      chk($sformatf("vec%0d.bad", i), b, vecs[i].exp_bad);
      fetch(vecs[i].fid, g, b);
      chk($sformatf("vec%0d.refetch", i), g + 100 * b, 0);
    end

    // two bad +7 entries saturate at +7
    do_reset();
    prog(4'd0, 1, 4'd3, 4'd5, 1, 4'sd7);
    prog(4'd1, 1, 4'd3, 4'd5, 1, 4'sd7);
    send_event(4'd3, 2'b10, busy);
    chk("sat.busy", busy, 16);
    fetch(4'd5, g, b);
    chk("sat.good", g, 0);
    chk("sat.bad", b, 7);

    // fetch in the same cycle entry 4 is scanned
    do_reset();
    prog(4'd0, 1, 4'd3, 4'd5, 0, 4'sd1);
    prog(4'd4, 1, 4'd3, 4'd5, 0, 4'sd3);
    bus.ev_valid = 1'b1; bus.ev_source = 4'd3; bus.ev_startstop = 2'b10;
    tick();
    bus.ev_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    bus.fetch_en = 1'b1; bus.fetch_id = 4'd5;
    tick();
    bus.fetch_en = 1'b0;
    chk("race.pre_add", int'(bus.new_good_tokens), 1);
    tick();
    chk("race.idle_out", int'(bus.new_good_tokens), 0);
    wait_idle(busy);
    chk("race.scan_ends", int'(busy < 40), 1);
    fetch(4'd5, g, b);
    chk("race.post_add", g, 3);

    // programming during a scan is discarded
    do_reset();
    prog(4'd0, 1, 4'd3, 4'd5, 0, 4'sd2);
    chk("drop.clear", int'(bus.prog_dropped), 0);
    bus.ev_valid = 1'b1; bus.ev_source = 4'd3; bus.ev_startstop = 2'b10;
    tick();
    bus.ev_valid = 1'b0;
    tick();
    prog(4'd0, 1, 4'd3, 4'd5, 0, 4'sd5);
    chk("drop.flag", int'(bus.prog_dropped), 1);
    wait_idle(busy);
    fetch(4'd5, g, b);
    chk("drop.first", g, 2);
    send_event(4'd3, 2'b10, busy);
    fetch(4'd5, g, b);
    chk("drop.unchanged", g, 2);
    chk("drop.sticky", int'(bus.prog_dropped), 1);

    // reset mid-scan aborts and clears partial adds
    bus.ev_valid = 1'b1; bus.ev_source = 4'd3; bus.ev_startstop = 2'b10;
    tick();
    bus.ev_valid = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    do_reset();
    tick();
    chk("abort.ev_ready", int'(bus.ev_ready), 1);
    chk("abort.prog_dropped", int'(bus.prog_dropped), 0);
    fetch(4'd5, g, b);
    chk("abort.fetch", g + 100 * b, 0);

    // programming alongside a no-op event transfer is discarded
    do_reset();
    bus.ev_valid = 1'b1; bus.ev_source = 4'd3; bus.ev_startstop = 2'b00;
    bus.prog_en = 1'b1; bus.prog_addr = 4'd0; bus.prog_entry_valid = 1'b1;
    bus.prog_source = 4'd3; bus.prog_target = 4'd5; bus.prog_is_bad = 1'b0; bus.prog_weight = 4'sd2;
    tick();
    bus.ev_valid = 1'b0; bus.prog_en = 1'b0;
    chk("evdrop.ready", int'(bus.ev_ready), 1);
    chk("evdrop.flag", int'(bus.prog_dropped), 1);
    send_event(4'd3, 2'b10, busy);
    chk("evdrop.busy", busy, 16);
    fetch(4'd5, g, b);
    chk("evdrop.good", g, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
